// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM encoding, counter width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned CNT_W     = $clog2(MDU_WIDTH);

  localparam logic MDU_OP_MULTU = 1'b0;
  localparam logic MDU_OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    shifted  = acc[2*WIDTH-1:WIDTH-1];
    diff     = shifted - {1'b0, operand};
    acc_next = acc;
    q_bit    = 1'b0;
    if (op == MDU_OP_MULTU) begin
      // Carry out of the add lands in the top bit as the accumulator shifts right.
      acc_next = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      // Top half is the partial remainder, bottom half shifts dividend bits out and
      // quotient bits in; the quotient bit itself is merged by the caller.
      q_bit    = ~diff[WIDTH];
      acc_next = {(q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// Iterative unsigned multiply/divide unit owning HI/LO; one step per clock, results
// committed to HI/LO only when the last step completes.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  mdu_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               op_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dz_q;

  logic [2*WIDTH-1:0] step_acc;
  logic               step_q_bit;
  logic [2*WIDTH-1:0] acc_adv;
  logic               cnt_last;
  logic               accept;
  logic               commit;

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op       (op_q),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (step_acc),
    .q_bit    (step_q_bit)
  );

  assign acc_adv  = {step_acc[2*WIDTH-1:1], (op_q == MDU_OP_DIVU) ? step_q_bit : step_acc[0]};
  assign cnt_last = (cnt_q == CntW'(WIDTH - 1));
  assign accept   = start && (state_q != MDU_RUN);
  assign commit   = (state_q == MDU_RUN) && cnt_last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MDU_IDLE: if (start) state_d = MDU_RUN;
      MDU_RUN:  if (cnt_last) state_d = MDU_DONE;
      MDU_DONE: state_d = start ? MDU_RUN : MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MDU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      op_q   <= MDU_OP_MULTU;
    end else if (accept) begin
      op_q   <= op;
      cnt_q  <= '0;
      // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
      acc_q  <= (op == MDU_OP_MULTU) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      opnd_q <= (op == MDU_OP_MULTU) ? a : b;
    end else if (state_q == MDU_RUN) begin
      acc_q  <= acc_adv;
      cnt_q  <= cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= acc_adv[2*WIDTH-1:WIDTH];
      lo_q <= acc_adv[WIDTH-1:0];
    end else if (!busy && !accept) begin
      if (hi_we) hi_q <= wd;
      if (lo_we) lo_q <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dz_q <= 1'b0;
    end else if (accept) begin
      dz_q <= 1'b0;
    end else if (commit) begin
      dz_q <= (op_q == MDU_OP_DIVU) && (opnd_q == '0);
    end
  end

  assign busy = (state_q == MDU_RUN);
  assign done = (state_q == MDU_DONE);
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: expected HI/LO/dz queued at launch, compared at done.
module tb_hilo_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wd = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];

  hilo_mdu #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    if (!o) begin
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
      e.dz = 1'b0;
    end else if (y == '0) begin
      e.hi = x;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      e.hi = x % y;
      e.lo = x / y;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drives start for the current cycle and queues the expected result; caller aligns to negedge.
  task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb.push_back(model(o, x, y));
  endtask

  // Waits (bounded) for done; reports cycles elapsed and busy cycles seen. Drops start.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      start = 1'b0;
      op    = ~op;
      a     = ~a;
      b     = b + 32'd17;
    end while (!done && cyc < 100);
  endtask

  task automatic test_reset();
    exp_t r;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    r = '{hi: hi, lo: lo, dz: dz};
    checks++;
    if ({busy, done, r} !== {2'b00, 64'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h dz=%b required all zero",
               busy, done, hi, lo, dz);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu();
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    int cyc, nb;
    exp_t e;
    xs = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 32'h8000_0001};
    ys = '{32'hFFFF_FFFF, 32'h9ABC_DEF0, 32'hDEAD_BEEF, 32'h0000_0003};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      launch(1'b0, xs[i], ys[i]);
      wait_done(cyc, nb);
      e = sb.pop_front();
      checks++;
      if (!done || cyc != 33 || nb != 32) begin
        failures++;
        $display("FAIL multu_timing[%0d]: done=%b cycles=%0d busy_cycles=%0d required 1/33/32",
                 i, done, cyc, nb);
      end
      checks++;
      if ({hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
        failures++;
        $display("FAIL multu_result[%0d]: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
                 i, hi, lo, dz, e.hi, e.lo, e.dz);
      end
    end
  endtask

  task automatic test_divu();
    logic [W-1:0] xs[5];
    logic [W-1:0] ys[5];
    int cyc, nb;
    exp_t e;
    xs = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, $urandom()};
    ys = '{32'd7, 32'd1, 32'd9, 32'hFFFF_FFFF, $urandom_range(1, 1000)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      launch(1'b1, xs[i], ys[i]);
      wait_done(cyc, nb);
      e = sb.pop_front();
      checks++;
      if (!done || cyc != 33 || nb != 32) begin
        failures++;
        $display("FAIL divu_timing[%0d]: done=%b cycles=%0d busy_cycles=%0d required 1/33/32",
                 i, done, cyc, nb);
      end
      checks++;
      if ({hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
        failures++;
        $display("FAIL divu_result[%0d] %0d/%0d: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
                 i, xs[i], ys[i], hi, lo, dz, e.hi, e.lo, e.dz);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc, nb;
    exp_t e;
    @(negedge clk);
    launch(1'b1, 32'h1234_5678, 32'd0);
    wait_done(cyc, nb);
    e = sb.pop_front();
    checks++;
    if (!done || cyc != 33 || {hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
      failures++;
      $display("FAIL divzero: done=%b cycles=%0d hi=%h lo=%h dz=%b required 1/33 hi=%h lo=%h dz=%b",
               done, cyc, hi, lo, dz, e.hi, e.lo, e.dz);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (dz !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL divzero_hold: dz=%b done=%b required dz=1 done=0", dz, done);
    end
    launch(1'b0, 32'd1, 32'd1);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (dz !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL divzero_clear: dz=%b busy=%b required dz=0 busy=1", dz, busy);
    end
    wait_done(cyc, nb);
    e = sb.pop_front();
    checks++;
    if (!done || {hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
      failures++;
      $display("FAIL divzero_next: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
               hi, lo, dz, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    exp_t e;
    @(negedge clk);
    launch(1'b0, 32'd3, 32'd5);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (cyc == 10);
      if (cyc == 10) begin
        op = 1'b0;
        a  = 32'd9;
        b  = 32'd9;
      end
    end while (!done && cyc < 100);
    e = sb.pop_front();
    checks++;
    if (!done || cyc != 33 || {hi, lo} !== {e.hi, e.lo}) begin
      failures++;
      $display("FAIL ignored_start: done=%b cycles=%0d hi=%h lo=%h required 1/33 hi=%h lo=%h",
               done, cyc, hi, lo, e.hi, e.lo);
    end
    launch(1'b0, 32'd2, 32'd4);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: done=%b busy=%b required done=0 busy=1", done, busy);
    end
    wait_done(cyc, nb);
    e = sb.pop_front();
    checks++;
    if (!done || cyc != 32 || {hi, lo} !== {e.hi, e.lo}) begin
      failures++;
      $display("FAIL b2b_result: done=%b cycles_after=%0d hi=%h lo=%h required 1/32 hi=%h lo=%h",
               done, cyc, hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, nb;
    exp_t e;
    @(negedge clk);
    launch(1'b0, 32'd100, 32'd200);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required all zero", busy, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    launch(1'b0, 32'd6, 32'd7);
    wait_done(cyc, nb);
    e = sb.pop_front();
    checks++;
    if (!done || cyc != 33 || {hi, lo} !== {e.hi, e.lo}) begin
      failures++;
      $display("FAIL reset_recover: cycles=%0d hi=%h lo=%h required 33 hi=%h lo=%h",
               cyc, hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_mt_writes();
    int cyc, nb;
    exp_t e;
    @(negedge clk);
    lo_we = 1'b1;
    wd    = 32'h0000_CAFE;
    @(negedge clk);
    lo_we = 1'b0;
    hi_we = 1'b1;
    wd    = 32'h0000_BEEF;
    checks++;
    if (lo !== 32'h0000_CAFE) begin
      failures++;
      $display("FAIL mtlo_idle: lo=%h required 0000cafe", lo);
    end
    @(negedge clk);
    lo_we = 1'b1;
    wd    = 32'h0000_1234;
    checks++;
    if (hi !== 32'h0000_BEEF || lo !== 32'h0000_CAFE) begin
      failures++;
      $display("FAIL mthi_idle: hi=%h lo=%h required 0000beef 0000cafe", hi, lo);
    end
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'h0000_1234) begin
      failures++;
      $display("FAIL mt_both: hi=%h lo=%h required 00001234 00001234", hi, lo);
    end
    launch(1'b0, 32'd2, 32'd3);
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b1;
    wd    = 32'h0000_DEAD;
    @(negedge clk);
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'h0000_1234 || hi !== 32'h0000_1234) begin
      failures++;
      $display("FAIL mt_busy: hi=%h lo=%h required 00001234 00001234", hi, lo);
    end
    wait_done(cyc, nb);
    e = sb.pop_front();
    checks++;
    if (!done || {hi, lo} !== {e.hi, e.lo}) begin
      failures++;
      $display("FAIL mt_busy_result: hi=%h lo=%h required hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
    launch(1'b1, 32'd50, 32'd5);
    hi_we = 1'b1;
    wd    = 32'h0000_FFFF;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    checks++;
    if (hi !== e.hi || busy !== 1'b1) begin
      failures++;
      $display("FAIL mt_with_start: hi=%h busy=%b required hi=%h busy=1", hi, busy, e.hi);
    end
    wait_done(cyc, nb);
    e = sb.pop_front();
    checks++;
    if (!done || cyc != 32 || {hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
      failures++;
      $display("FAIL mt_start_result: cycles_after=%0d hi=%h lo=%h required 32 hi=%h lo=%h",
               cyc, hi, lo, e.hi, e.lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_mt_writes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
